// File: rtl/mux_nxw_scan.sv
// mux_nxw_scan
// N-channel, W-bit registered multiplexer with clock enable. It feeds parallel
// channel outputs into a single-lane consumer. There are two modes:
//   MODE=0 : static select. The channel comes from SEL.
//   MODE=1 : scan. An internal counter visits the channels round-robin, one
//            channel per enabled clock.
// The output data carries a channel tag, a valid strobe and an end-of-frame
// marker. Latency is one cycle, and there is no combinational path from D to Q.
//
// Ports
//   CLK  : clock; all state changes on the rising edge
//   RST  : synchronous reset, active low; it dominates CE and MODE
//   CE   : clock enable for the output register and the scan counter
//   MODE : 0 = static, 1 = scan
//   SEL  : channel select, used in static mode only
//   D    : packed channel inputs; channel k is D[k*W +: W]
//   Q    : registered data
//   QCH  : registered channel tag for Q
//   QV   : one-cycle valid strobe per update
//   QEOF : high together with QV on the last channel of a scan frame
module mux_nxw_scan #(
   parameter int W    = 24,
   parameter int N    = 4,
   parameter int SELW = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CE,
   input  logic              MODE,
   input  logic [SELW-1:0]   SEL,
   input  logic [N*W-1:0]    D,
   output logic [W-1:0]      Q,
   output logic [SELW-1:0]   QCH,
   output logic              QV,
   output logic              QEOF
);

   localparam logic [SELW-1:0] LAST = SELW'(N - 1);

   logic [W-1:0]    q_q, q_d;
   logic [SELW-1:0] qch_q, qch_d;
   logic            qv_q, qv_d;
   logic            qeof_q, qeof_d;
   logic [SELW-1:0] cnt_q, cnt_d;
   logic            mode_d_q, mode_d_d;
   logic            restart_q, restart_d;

   logic            restart;
   logic [SELW-1:0] scan_ch;
   logic [SELW-1:0] idx;
   logic [W-1:0]    pick;

   always_comb begin
      // A MODE rise is detected every cycle, including cycles with CE low.
      // The restart flag remembers that rise until the next enabled scan cycle.
      restart = restart_q | (MODE & ~mode_d_q);
      scan_ch = restart ? '0 : cnt_q;
      idx     = MODE ? scan_ch : SEL;

      pick = '0;
      for (int k = 0; k < N; k++) begin
         if (idx == SELW'(k)) pick = D[k*W +: W];
      end

      q_d       = q_q;
      qch_d     = qch_q;
      qv_d      = 1'b0;
      qeof_d    = 1'b0;
      cnt_d     = cnt_q;
      mode_d_d  = MODE;
      restart_d = restart;

      if (CE) begin
         if (!MODE) begin
            // A SEL value above N-1 yields zero data and no valid strobe,
            // but the tag still reports SEL.
            qch_d = SEL;
            cnt_d = '0;
            if (SEL <= LAST) begin
               q_d  = pick;
               qv_d = 1'b1;
            end else begin
               q_d  = '0;
            end
         end else begin
            q_d       = pick;
            qch_d     = scan_ch;
            qv_d      = 1'b1;
            qeof_d    = (scan_ch == LAST);
            cnt_d     = (scan_ch == LAST) ? '0 : scan_ch + 1'b1;
            restart_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         q_q       <= '0;
         qch_q     <= '0;
         qv_q      <= 1'b0;
         qeof_q    <= 1'b0;
         cnt_q     <= '0;
         mode_d_q  <= 1'b0;
         restart_q <= 1'b0;
      end else begin
         q_q       <= q_d;
         qch_q     <= qch_d;
         qv_q      <= qv_d;
         qeof_q    <= qeof_d;
         cnt_q     <= cnt_d;
         mode_d_q  <= mode_d_d;
         restart_q <= restart_d;
      end
   end

   assign Q    = q_q;
   assign QCH  = qch_q;
   assign QV   = qv_q;
   assign QEOF = qeof_q;

endmodule

// File: tb/tb_mux_nxw_scan.sv
module tb_mux_nxw_scan;

   logic          clk = 1'b0;
   logic          rst, ce, mode;
   logic [1:0]    sel;
   logic [95:0]   d4;
   logic [23:0]   d3;
   logic [23:0]   q4;
   logic [1:0]    qch4;
   logic          qv4, qeof4;
   logic [7:0]    q3;
   logic [1:0]    qch3;
   logic          qv3, qeof3;

   int errors = 0;
   int checks = 0;

   logic [23:0] ch4 [4] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
   logic [7:0]  ch3 [3] = '{8'hA1, 8'hB2, 8'hC3};

   always #5 clk = ~clk;

   mux_nxw_scan #(.W(24), .N(4), .SELW(2)) u4 (
      .CLK(clk), .RST(rst), .CE(ce), .MODE(mode), .SEL(sel), .D(d4),
      .Q(q4), .QCH(qch4), .QV(qv4), .QEOF(qeof4));

   mux_nxw_scan #(.W(8), .N(3), .SELW(2)) u3 (
      .CLK(clk), .RST(rst), .CE(ce), .MODE(mode), .SEL(sel), .D(d3),
      .Q(q3), .QCH(qch3), .QV(qv3), .QEOF(qeof3));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one enabled/disabled cycle on the N=4 instance, full output check
   task automatic chk4(input string tag, input logic [23:0] eq, input logic [1:0] ech,
                       input logic ev, input logic eeof);
      chk({tag, ".q"},    32'(q4),    32'(eq));
      chk({tag, ".qch"},  32'(qch4),  32'(ech));
      chk({tag, ".qv"},   32'(qv4),   32'(ev));
      chk({tag, ".qeof"}, 32'(qeof4), 32'(eeof));
   endtask

   initial begin
      logic [3:0] ce_pat [6] = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1};
      int ch;

      // reset with CE=1, MODE=1 and junk data
      rst = 1'b0; ce = 1'b1; mode = 1'b1; sel = 2'd0;
      d4 = {24'hDEAD01, 24'hBEEF02, 24'hCAFE03, 24'hF00D04};
      d3 = 24'h5A5A5A;
      tick(); tick();
      chk4("rst", 24'h0, 2'd0, 1'b0, 1'b0);
      chk("rst3.q", 32'(q3), 32'h0);

      d4 = {ch4[3], ch4[2], ch4[1], ch4[0]};
      d3 = {ch3[2], ch3[1], ch3[0]};
      rst = 1'b1;
      tick();
      chk4("post_rst", ch4[0], 2'd0, 1'b1, 1'b0);

      // static select SEL=2, then hold with CE=0
      mode = 1'b0; sel = 2'd2;
      tick();
      chk4("static2", ch4[2], 2'd2, 1'b1, 1'b0);
      ce = 1'b0;
      tick();
      chk4("hold", ch4[2], 2'd2, 1'b0, 1'b0);

      // scan for 9 cycles starting fresh at channel 0
      ce = 1'b1; mode = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk4($sformatf("scan%0d", i), ch4[i%4], 2'(i%4), 1'b1, (i%4) == 3);
      end

      // back to static for one cycle, then scan with CE gaps
      mode = 1'b0; sel = 2'd1;
      tick();
      chk4("static1", ch4[1], 2'd1, 1'b1, 1'b0);
      mode = 1'b1;
      ch = 0;
      for (int i = 0; i < 6; i++) begin
         ce = ce_pat[i][0];
         tick();
         if (ce) begin
            chk4($sformatf("gap%0d", i), ch4[ch], 2'(ch), 1'b1, ch == 3);
            ch++;
         end else begin
            chk4($sformatf("gap%0d", i), ch4[ch-1], 2'(ch-1), 1'b0, 1'b0);
         end
      end

      // reset mid-frame, then N=3 scan wraps at 3
      ce = 1'b1;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("n3_%0d.q", i),    32'(q3),    32'(ch3[i%3]));
         chk($sformatf("n3_%0d.qch", i),  32'(qch3),  32'(i%3));
         chk($sformatf("n3_%0d.qeof", i), 32'(qeof3), 32'((i%3) == 2));
         chk($sformatf("n3_%0d.qv", i),   32'(qv3),   32'h1);
      end

      // out-of-range select on N=3, in-range on N=4
      mode = 1'b0; sel = 2'd3;
      tick();
      chk("oor.q",   32'(q3),   32'h0);
      chk("oor.qch", 32'(qch3), 32'h3);
      chk("oor.qv",  32'(qv3),  32'h0);
      chk("oor.eof", 32'(qeof3), 32'h0);
      chk4("sel3", ch4[3], 2'd3, 1'b1, 1'b0);

      // abandon a frame at channel 2, re-enter scan: restart at 0
      mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk4($sformatf("pre%0d", i), ch4[i], 2'(i), 1'b1, 1'b0);
      end
      mode = 1'b0; sel = 2'd1;
      tick();
      chk4("abandon", ch4[1], 2'd1, 1'b1, 1'b0);
      mode = 1'b1;
      tick();
      chk4("reenter", ch4[0], 2'd0, 1'b1, 1'b0);
      tick();
      chk4("reenter1", ch4[1], 2'd1, 1'b1, 1'b0);

      // MODE falls and rises entirely while CE=0: next enabled scan restarts
      ce = 1'b0; mode = 1'b0;
      tick();
      mode = 1'b1;
      tick();
      chk4("ce0hold", ch4[1], 2'd1, 1'b0, 1'b0);
      ce = 1'b1;
      tick();
      chk4("sticky", ch4[0], 2'd0, 1'b1, 1'b0);
      tick();
      chk4("sticky1", ch4[1], 2'd1, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
